alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Consumer end of the ROB dispatch interface. Accepts one renamed instruction per cycle (operands as value or ROB tag), holds it until both operands are resolved by snooping the ALU and memory result broadcasts, then issues the oldest ready entry to the ALU.
- Returns back-pressure to the ROB through rs_full. The ALU result returns to the ROB tagged with alu_tag.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 3, ROB tag width; tag 0 means "no tag / value valid"
XLEN, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all entries (mispredict)
target  in  TAG_W  ROB tag of dispatched instruction; 0 = no dispatch this cycle
op_in  in  5  opcode (ROB encoding)
value1  in  XLEN  operand 1 value, valid when query1==0
query1  in  TAG_W  operand 1 producer tag, 0 = ready
value2  in  XLEN  operand 2 value
query2  in  TAG_W  operand 2 producer tag
imm_in  in  XLEN  immediate, carried to ALU
cdb_alu_num  in  TAG_W  ALU broadcast tag, 0 = none
cdb_alu_value  in  XLEN  ALU broadcast value
cdb_mem_num  in  TAG_W  memory broadcast tag, 0 = none
cdb_mem_value  in  XLEN  memory broadcast value
rs_full  out  1  registered back-pressure to ROB
alu_valid  out  1  registered issue strobe
alu_op  out  5  issued opcode
alu_a  out  XLEN  issued operand 1
alu_b  out  XLEN  issued operand 2
alu_imm  out  XLEN  issued immediate
alu_tag  out  TAG_W  issued ROB tag
overflow  out  1  sticky: dispatch arrived with no free entry

Behaviour:
- Reset (rst low, async): all entries invalid, age matrix cleared. rs_full=0, alu_valid=0, alu_op=5'b11111, alu_a/alu_b/alu_imm=0, alu_tag=0, overflow=0.
- Entry state: valid, op, v1, q1, v2, q2, imm, tag. Age matrix older[i][j] is DEPTH x DEPTH bits.
- Allocation (target!=0): write the lowest-index free entry at the edge. On allocate of entry k, set older[j][k]=1 for every currently valid j, and older[k][*]=0.
- No free entry at dispatch: instruction dropped, overflow set (cleared only by reset).
- Dispatch-cycle bypass: if query1/2 equals a nonzero cdb tag in the same cycle, store the cdb value and q=0.
- Wakeup: for each valid entry with qX!=0 and qX==cdb_alu_num, set vX<=cdb_alu_value and qX<=0. Same rule for mem. If both buses carry the same tag, the ALU bus wins.
- Ready = valid && q1==0 && q2==0, evaluated on registered state only. An entry woken or allocated at edge N is first issuable at edge N+1.
- Issue at each edge:
  - Select the ready entry with no older ready entry (age matrix).
  - Register alu_valid=1 plus op/v1/v2/imm/tag, and invalidate the entry.
  - If nothing is ready: alu_valid=0; other alu_* hold their previous values.
- At most one allocation and one issue per edge. The issued entry's slot is free for an allocation in the same edge only at the next edge (allocator sees pre-edge valid bits).
- Latency: dispatch with ready operands at edge k gives alu_valid high in the cycle after edge k+1.
- rs_full register = (valid count after this edge) >= DEPTH-1. This one-slot slack covers the ROB's one-cycle reaction delay.
- flush=1: at the edge all entries are invalidated, alu_valid<=0, rs_full<=0, and age cleared. A dispatch or issue in the same cycle is discarded. overflow is kept.
- Tag widths: compares are full TAG_W. Tag 0 is never matched as a producer.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
- Ready dispatch: target=3, op=ADD, q1=q2=0, v1=5, v2=7 at edge 0 -> edge 1 gives alu_valid=1, alu_tag=3, alu_a=5, alu_b=7; next cycle alu_valid=0.
- Wakeup: target=2, q1=4 at edge 0; cdb_alu_num=4, cdb_alu_value=0x10 at edge 2 -> issue at edge 3 with alu_a=0x10, tag=2. Same-cycle bypass variant (cdb tag 4 with dispatch) -> issue at edge 1.
- Age order: dispatch tag 5 (q1=6) then tag 6 (ready), then broadcast 6 -> tag 6 issues first; tag 5 issues on the edge after it becomes ready, not before.
- Fill: 3 dispatches with unresolved tags (DEPTH=4) -> rs_full=1 after the 3rd edge. 5th dispatch with all entries waiting -> dropped, overflow=1.
- Flush: 2 waiting entries, flush plus simultaneous dispatch -> all invalid, alu_valid=0, rs_full=0, no later issue for those tags.
- Async reset: drop rst between edges while alu_valid=1 -> alu_valid=0 and alu_op=5'b11111 immediately. After release, a dispatch behaves as in the ready-dispatch scenario.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Bundles the ROB dispatch port, the two result broadcast buses, and the ALU issue port
// of the ALU reservation station.
interface alu_reservation_station_if #(
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
);
    logic [TAG_W-1:0] target;
    logic [4:0]       op_in;
    logic [XLEN-1:0]  value1;
    logic [TAG_W-1:0] query1;
    logic [XLEN-1:0]  value2;
    logic [TAG_W-1:0] query2;
    logic [XLEN-1:0]  imm_in;
    logic [TAG_W-1:0] cdb_alu_num;
    logic [XLEN-1:0]  cdb_alu_value;
    logic [TAG_W-1:0] cdb_mem_num;
    logic [XLEN-1:0]  cdb_mem_value;
    logic             rs_full;
    logic             alu_valid;
    logic [4:0]       alu_op;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_imm;
    logic [TAG_W-1:0] alu_tag;

    modport slave (
        input  target, op_in, value1, query1, value2, query2, imm_in,
        input  cdb_alu_num, cdb_alu_value, cdb_mem_num, cdb_mem_value,
        output rs_full, alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_tag
    );

    modport master (
        output target, op_in, value1, query1, value2, query2, imm_in,
        output cdb_alu_num, cdb_alu_value, cdb_mem_num, cdb_mem_value,
        input  rs_full, alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_tag
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed instructions until both operands are resolved
// from the ALU/memory broadcasts, then issues the oldest ready one (age matrix order).
module alu_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    alu_reservation_station_if.slave rs_if,
    output logic                     overflow_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] LSB_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       op_q  [DEPTH];
    logic [4:0]       op_d  [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v1_d  [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q1_d  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [XLEN-1:0]  v2_d  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [TAG_W-1:0] q2_d  [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  imm_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    // older_q[j][i] = 1 means entry j was allocated before entry i
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    logic [DEPTH-1:0] ready_s, blocked_s, grant_s, iss_mask_s, free_s, alloc_mask_s;
    logic             iss_any_s, alloc_s, drop_s;
    logic [CNT_W-1:0] cnt_s;
    logic [4:0]       iss_op_s;
    logic [XLEN-1:0]  iss_a_s, iss_b_s, iss_imm_s;
    logic [TAG_W-1:0] iss_tag_s;

    logic             rs_full_q, alu_valid_q, overflow_q;
    logic [4:0]       alu_op_q;
    logic [XLEN-1:0]  alu_a_q, alu_b_q, alu_imm_q;
    logic [TAG_W-1:0] alu_tag_q;

    // Operand snoop: a nonzero producer tag matching a broadcast takes its value; ALU bus wins.
    function automatic logic [TAG_W+XLEN-1:0] snoop(
        input logic [TAG_W-1:0] q,
        input logic [XLEN-1:0]  v,
        input logic [TAG_W-1:0] an,
        input logic [XLEN-1:0]  av,
        input logic [TAG_W-1:0] mn,
        input logic [XLEN-1:0]  mv
    );
        logic [TAG_W+XLEN-1:0] r;
        if ((q != {TAG_W{1'b0}}) && (q == an)) begin
            r = {{TAG_W{1'b0}}, av};
        end else if ((q != {TAG_W{1'b0}}) && (q == mn)) begin
            r = {{TAG_W{1'b0}}, mv};
        end else begin
            r = {q, v};
        end
        return r;
    endfunction

    // Readiness and oldest-ready selection from registered state only.
    always_comb begin
        ready_s   = '0;
        blocked_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = valid_q[i] && (q1_q[i] == {TAG_W{1'b0}}) && (q2_q[i] == {TAG_W{1'b0}});
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s[i] = blocked_s[i] | (ready_s[j] & older_q[j][i]);
            end
        end
        grant_s    = ready_s & ~blocked_s;
        iss_mask_s = grant_s & (~grant_s + LSB_ONE);
        iss_any_s  = (|iss_mask_s) && !flush_i;
        free_s     = ~valid_q;
        alloc_s    = (rs_if.target != {TAG_W{1'b0}}) && (|free_s) && !flush_i;
        drop_s     = (rs_if.target != {TAG_W{1'b0}}) && !(|free_s) && !flush_i;
        alloc_mask_s = alloc_s ? (free_s & (~free_s + LSB_ONE)) : {DEPTH{1'b0}};
    end

    // Issue-field mux from the selected entry.
    always_comb begin
        iss_op_s  = 5'b00000;
        iss_a_s   = '0;
        iss_b_s   = '0;
        iss_imm_s = '0;
        iss_tag_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_op_s  = iss_op_s  | (iss_mask_s[i] ? op_q[i]  : 5'b00000);
            iss_a_s   = iss_a_s   | (iss_mask_s[i] ? v1_q[i]  : {XLEN{1'b0}});
            iss_b_s   = iss_b_s   | (iss_mask_s[i] ? v2_q[i]  : {XLEN{1'b0}});
            iss_imm_s = iss_imm_s | (iss_mask_s[i] ? imm_q[i] : {XLEN{1'b0}});
            iss_tag_s = iss_tag_s | (iss_mask_s[i] ? tag_q[i] : {TAG_W{1'b0}});
        end
    end

    // Entry next state: allocate with dispatch bypass, otherwise snoop both buses.
    always_comb begin
        op_d  = op_q;
        v1_d  = v1_q;
        q1_d  = q1_q;
        v2_d  = v2_q;
        q2_d  = q2_q;
        imm_d = imm_q;
        tag_d = tag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_mask_s[i]) begin
                op_d[i]  = rs_if.op_in;
                imm_d[i] = rs_if.imm_in;
                tag_d[i] = rs_if.target;
                {q1_d[i], v1_d[i]} = snoop(rs_if.query1, rs_if.value1, rs_if.cdb_alu_num,
                                           rs_if.cdb_alu_value, rs_if.cdb_mem_num, rs_if.cdb_mem_value);
                {q2_d[i], v2_d[i]} = snoop(rs_if.query2, rs_if.value2, rs_if.cdb_alu_num,
                                           rs_if.cdb_alu_value, rs_if.cdb_mem_num, rs_if.cdb_mem_value);
            end else begin
                {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i], rs_if.cdb_alu_num,
                                           rs_if.cdb_alu_value, rs_if.cdb_mem_num, rs_if.cdb_mem_value);
                {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i], rs_if.cdb_alu_num,
                                           rs_if.cdb_alu_value, rs_if.cdb_mem_num, rs_if.cdb_mem_value);
            end
        end
    end

    // Valid bits, age matrix and post-edge occupancy.
    always_comb begin
        if (flush_i) begin
            valid_d = '0;
        end else begin
            valid_d = (valid_q & ~iss_mask_s) | alloc_mask_s;
        end
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_d[j][i] = flush_i         ? 1'b0 :
                                alloc_mask_s[j] ? 1'b0 :
                                alloc_mask_s[i] ? valid_q[j] : older_q[j][i];
            end
        end
        cnt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_s = cnt_s + CNT_W'(valid_d[i]);
        end
    end

    // Entry storage and age matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= 5'b00000;
                v1_q[i]    <= '0;
                q1_q[i]    <= '0;
                v2_q[i]    <= '0;
                q2_q[i]    <= '0;
                imm_q[i]   <= '0;
                tag_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            v1_q    <= v1_d;
            q1_q    <= q1_d;
            v2_q    <= v2_d;
            q2_q    <= q2_d;
            imm_q   <= imm_d;
            tag_q   <= tag_d;
            older_q <= older_d;
        end
    end

    // Registered issue port, back-pressure and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_full_q   <= 1'b0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= 5'b11111;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_imm_q   <= '0;
            alu_tag_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rs_full_q   <= (cnt_s >= CNT_W'(DEPTH - 1));
            alu_valid_q <= iss_any_s;
            if (iss_any_s) begin
                alu_op_q  <= iss_op_s;
                alu_a_q   <= iss_a_s;
                alu_b_q   <= iss_b_s;
                alu_imm_q <= iss_imm_s;
                alu_tag_q <= iss_tag_s;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rs_if.rs_full   = rs_full_q;
    assign rs_if.alu_valid = alu_valid_q;
    assign rs_if.alu_op    = alu_op_q;
    assign rs_if.alu_a     = alu_a_q;
    assign rs_if.alu_b     = alu_b_q;
    assign rs_if.alu_imm   = alu_imm_q;
    assign rs_if.alu_tag   = alu_tag_q;
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus random traffic, checked
// every cycle against an age-ordered queue model of the station.
module tb_alu_reservation_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 3;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic overflow;

    alu_reservation_station_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .rs_if      (bus),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [2:0]  q1;
        logic [31:0] v2;
        logic [2:0]  q2;
        logic [31:0] imm;
        logic [2:0]  tag;
    } ent_t;

    ent_t        mq[$];
    logic        e_valid, e_full, e_ovf;
    logic [4:0]  e_op;
    logic [31:0] e_a, e_b, e_imm;
    logic [2:0]  e_tag;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_valid = 1'b0; e_full = 1'b0; e_ovf = 1'b0;
        e_op = 5'h1f; e_a = 32'd0; e_b = 32'd0; e_imm = 32'd0; e_tag = 3'd0;
    endtask

    function automatic void wake(input logic [2:0] q, input logic [31:0] v,
                                 output logic [2:0] qo, output logic [31:0] vo);
        qo = q; vo = v;
        if (q != 3'd0) begin
            if (q == bus.cdb_alu_num) begin
                qo = 3'd0; vo = bus.cdb_alu_value;
            end else if (q == bus.cdb_mem_num) begin
                qo = 3'd0; vo = bus.cdb_mem_value;
            end
        end
    endfunction

    // Queue is kept oldest-first, so the first ready element is the one that must issue.
    task automatic model_step();
        int          iss;
        int          pre_size;
        ent_t        ne;
        logic [2:0]  q;
        logic [31:0] v;
        if (flush) begin
            mq.delete();
            e_valid = 1'b0;
            e_full  = 1'b0;
            return;
        end
        pre_size = mq.size();
        iss = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (iss < 0 && mq[i].q1 == 3'd0 && mq[i].q2 == 3'd0) iss = i;
        end
        e_valid = (iss >= 0);
        if (iss >= 0) begin
            e_op = mq[iss].op; e_a = mq[iss].v1; e_b = mq[iss].v2;
            e_imm = mq[iss].imm; e_tag = mq[iss].tag;
            mq.delete(iss);
        end
        for (int i = 0; i < mq.size(); i++) begin
            wake(mq[i].q1, mq[i].v1, q, v); mq[i].q1 = q; mq[i].v1 = v;
            wake(mq[i].q2, mq[i].v2, q, v); mq[i].q2 = q; mq[i].v2 = v;
        end
        if (bus.target != 3'd0) begin
            if (pre_size >= DEPTH) begin
                e_ovf = 1'b1;
            end else begin
                ne.op = bus.op_in; ne.imm = bus.imm_in; ne.tag = bus.target;
                wake(bus.query1, bus.value1, ne.q1, ne.v1);
                wake(bus.query2, bus.value2, ne.q2, ne.v2);
                mq.push_back(ne);
            end
        end
        e_full = (mq.size() >= DEPTH - 1);
    endtask

    task automatic compare();
        chk("alu_valid", bus.alu_valid, e_valid);
        chk("alu_op", bus.alu_op, e_op);
        chk("alu_a", bus.alu_a, e_a);
        chk("alu_b", bus.alu_b, e_b);
        chk("alu_imm", bus.alu_imm, e_imm);
        chk("alu_tag", bus.alu_tag, e_tag);
        chk("rs_full", bus.rs_full, e_full);
        chk("overflow", overflow, e_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    task automatic idle();
        bus.target = 3'd0; bus.op_in = 5'd0; bus.imm_in = 32'd0;
        bus.value1 = 32'd0; bus.query1 = 3'd0; bus.value2 = 32'd0; bus.query2 = 3'd0;
        bus.cdb_alu_num = 3'd0; bus.cdb_alu_value = 32'd0;
        bus.cdb_mem_num = 3'd0; bus.cdb_mem_value = 32'd0;
        flush = 1'b0;
    endtask

    task automatic disp(input logic [2:0] t, input logic [4:0] op, input logic [31:0] v1,
                        input logic [2:0] q1, input logic [31:0] v2, input logic [2:0] q2,
                        input logic [31:0] imm);
        bus.target = t; bus.op_in = op; bus.value1 = v1; bus.query1 = q1;
        bus.value2 = v2; bus.query2 = q2; bus.imm_in = imm;
    endtask

    function automatic logic [2:0] rtag();
        return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    endfunction

    initial begin
        idle();
        model_reset();
        #12 rst_n = 1'b1;
        chk("rst_alu_valid", bus.alu_valid, 32'd0);
        chk("rst_alu_op", bus.alu_op, 32'h1f);
        chk("rst_rs_full", bus.rs_full, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
        compare();

        // Ready dispatch: issue one edge after allocation.
        idle(); disp(3'd3, 5'd1, 32'd5, 3'd0, 32'd7, 3'd0, 32'h100); cycle();
        chk("rd_e0_valid", bus.alu_valid, 32'd0);
        idle(); cycle();
        chk("rd_valid", bus.alu_valid, 32'd1);
        chk("rd_tag", bus.alu_tag, 32'd3);
        chk("rd_a", bus.alu_a, 32'd5);
        chk("rd_b", bus.alu_b, 32'd7);
        cycle();
        chk("rd_drop", bus.alu_valid, 32'd0);
        chk("rd_hold_tag", bus.alu_tag, 32'd3);

        // Wakeup from the ALU bus two edges after dispatch.
        idle(); disp(3'd2, 5'd2, 32'hdead, 3'd4, 32'd9, 3'd0, 32'd0); cycle();
        idle(); cycle();
        idle(); bus.cdb_alu_num = 3'd4; bus.cdb_alu_value = 32'h10; cycle();
        chk("wk_e2_valid", bus.alu_valid, 32'd0);
        idle(); cycle();
        chk("wk_valid", bus.alu_valid, 32'd1);
        chk("wk_a", bus.alu_a, 32'h10);
        chk("wk_tag", bus.alu_tag, 32'd2);

        // Dispatch-cycle bypass, and ALU bus winning over the memory bus.
        idle(); disp(3'd2, 5'd2, 32'hdead, 3'd4, 32'd9, 3'd0, 32'd0);
        bus.cdb_alu_num = 3'd4; bus.cdb_alu_value = 32'h20; cycle();
        idle(); cycle();
        chk("byp_valid", bus.alu_valid, 32'd1);
        chk("byp_a", bus.alu_a, 32'h20);
        idle(); disp(3'd1, 5'd3, 32'd0, 3'd5, 32'd0, 3'd5, 32'd0);
        bus.cdb_alu_num = 3'd5; bus.cdb_alu_value = 32'hA;
        bus.cdb_mem_num = 3'd5; bus.cdb_mem_value = 32'hB; cycle();
        idle(); cycle();
        chk("prio_a", bus.alu_a, 32'hA);
        chk("prio_b", bus.alu_b, 32'hA);

        // Age order: the younger ready entry goes before the just-woken older one.
        idle(); disp(3'd5, 5'd4, 32'd0, 3'd6, 32'd2, 3'd0, 32'd0); cycle();
        idle(); disp(3'd6, 5'd5, 32'h66, 3'd0, 32'd3, 3'd0, 32'd0); cycle();
        idle(); bus.cdb_alu_num = 3'd6; bus.cdb_alu_value = 32'h55; cycle();
        chk("age_first_tag", bus.alu_tag, 32'd6);
        chk("age_first_a", bus.alu_a, 32'h66);
        idle(); cycle();
        chk("age_second_valid", bus.alu_valid, 32'd1);
        chk("age_second_tag", bus.alu_tag, 32'd5);
        chk("age_second_a", bus.alu_a, 32'h55);
        cycle();

        // Fill with waiting entries, then overflow on the fifth dispatch.
        for (int t = 1; t <= 3; t++) begin
            idle(); disp(3'(t), 5'd0, 32'(t), 3'd7, 32'd0, 3'd0, 32'd0); cycle();
            if (t == 2) chk("fill_2_full", bus.rs_full, 32'd0);
        end
        chk("fill_3_full", bus.rs_full, 32'd1);
        idle(); disp(3'd4, 5'd0, 32'd4, 3'd7, 32'd0, 3'd0, 32'd0); cycle();
        chk("fill_4_ovf", overflow, 32'd0);
        idle(); disp(3'd5, 5'd0, 32'd5, 3'd7, 32'd0, 3'd0, 32'd0); cycle();
        chk("fill_5_ovf", overflow, 32'd1);

        // Flush with a simultaneous dispatch discards everything.
        idle(); disp(3'd6, 5'd0, 32'd1, 3'd0, 32'd1, 3'd0, 32'd0); flush = 1'b1; cycle();
        chk("fl_valid", bus.alu_valid, 32'd0);
        chk("fl_full", bus.rs_full, 32'd0);
        chk("fl_ovf_kept", overflow, 32'd1);
        idle(); bus.cdb_alu_num = 3'd7; bus.cdb_alu_value = 32'h77; cycle();
        idle(); repeat (3) cycle();
        chk("fl_no_issue", bus.alu_valid, 32'd0);

        // Asynchronous reset between edges while an issue is on the port.
        idle(); disp(3'd3, 5'd1, 32'd5, 3'd0, 32'd7, 3'd0, 32'd0); cycle();
        idle(); cycle();
        chk("ar_pre_valid", bus.alu_valid, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.alu_valid, 32'd0);
        chk("ar_op", bus.alu_op, 32'h1f);
        chk("ar_ovf", overflow, 32'd0);
        chk("ar_tag", bus.alu_tag, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        disp(3'd3, 5'd1, 32'd5, 3'd0, 32'd7, 3'd0, 32'd0); cycle();
        chk("ar_rd_e0", bus.alu_valid, 32'd0);
        idle(); cycle();
        chk("ar_rd_valid", bus.alu_valid, 32'd1);
        chk("ar_rd_a", bus.alu_a, 32'd5);

        // Random traffic against the queue model.
        for (int n = 0; n < 2000; n++) begin
            idle();
            if ($urandom_range(0, 9) < 6) begin
                disp(3'($urandom_range(1, 7)), 5'($urandom), $urandom, rtag(),
                     $urandom, rtag(), $urandom);
            end
            bus.cdb_alu_num = rtag(); bus.cdb_alu_value = $urandom;
            bus.cdb_mem_num = rtag(); bus.cdb_mem_value = $urandom;
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
